cordic_byte_host: RTL and testbench
===================================

Name: cordic_byte_host

Overview:
- Host-side link master for the byte-serial CORDIC wrapper.
- Accepts one parallel (X, Y) request and serialises it LSB-first as 4 bytes over the 8-bit link.
- Collects the 6 result bytes, then presents magnitude and phase as one parallel response.
- Sits between the system/SoC side and the CORDIC wrapper's ui_in/uo_out/uio byte link, so on-chip logic can use the wrapper without the wrapper being changed.

Parameters:
- WIDTH, 16, bit width of X, Y and magnitude; must be a multiple of 8.
- PHASE_W, 32, bit width of phase result; must be a multiple of 8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when CORDIC_HOST_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  parallel request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_x  in  WIDTH  signed X operand.
- req_y  in  WIDTH  signed Y operand.
- resp_valid  out  1  response holding registers valid.
- resp_ready  in  1  consumer accepts response.
- resp_mag  out  WIDTH  magnitude result.
- resp_phase  out  PHASE_W  phase result.
- resp_err  out  1  response aborted by watchdog (see Optional Feature); tied 0 otherwise.
- busy  out  1  high in any state other than IDLE.
- link_tx_data  out  8  byte to wrapper ui_in.
- link_tx_valid  out  1  drives wrapper in_valid.
- link_tx_ready  in  1  from wrapper in_ready.
- link_rx_data  in  8  from wrapper uo_out.
- link_rx_valid  in  1  from wrapper out_valid.
- link_rx_ready  out  1  drives wrapper out_ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 except req_ready=1. State IDLE; byte counter 0; shift registers 0.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready, capture {req_y, req_x} into a 2*WIDTH TX shift register, counter<=0, go to SEND.
  - SEND: link_tx_valid=1, link_tx_data = TX shift register [7:0].
    - A byte transfers on a cycle where link_tx_valid&link_tx_ready are both high; then shift right by 8 and counter++.
    - Byte order: X[7:0], X[15:8], …, Y[7:0], Y[15:8] (LSB-first, X before Y).
    - While link_tx_ready=0, hold data and valid stable.
    - After byte 2*WIDTH/8 transfers: link_tx_valid<=0, counter<=0, go to RECV.
  - RECV: link_rx_ready=1.
    - On link_rx_valid&link_rx_ready, shift link_rx_data into the MSB of a (WIDTH+PHASE_W) RX register (LSB-first reassembly) and counter++.
    - Byte order: mag LSB…MSB, then phase LSB…MSB.
    - After (WIDTH+PHASE_W)/8 bytes: link_rx_ready<=0, load resp_mag and resp_phase, go to DONE.
  - DONE: resp_valid=1 with data stable until resp_ready=1, then go to IDLE.
- Latency:
  - First tx byte presented 1 cycle after request accept.
  - resp_valid asserts the cycle after the last rx byte is accepted.
  - req_ready reasserts the cycle after the response handshake.
- The TX and RX sides are mutually exclusive. link_rx_valid is ignored outside RECV. link_tx_ready is ignored outside SEND.
- Counter width is clog2 of the larger byte count. The counter never wraps mid-transfer.
- No arithmetic beyond byte packing; sign is carried untouched in the MSB bytes.
- Reset mid-operation: state returns to IDLE next edge. Partial bytes are discarded and all link outputs drop to 0. No residual response is produced.
- req_valid while busy: ignored (req_ready=0); no queuing.

Optional Feature:
- Macro: CORDIC_HOST_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every link byte transfer and on state entry, and increments each cycle in SEND or RECV.
  - On reaching TIMEOUT_CYCLES: go to DONE with resp_err=1, resp_mag=0, resp_phase=0, and link_tx_valid and link_rx_ready deasserted.
  - resp_err clears on the response handshake.
- Not defined: no watchdog logic is built; resp_err is constant 0; the block waits on the link indefinitely.

Test Plan:
- Q1 request: X=12000 (0x2EE0), Y=8000 (0x1F40), link_tx_ready=1 -> link bytes E0,2E,40,1F on 4 consecutive cycles starting 1 cycle after accept.
- Response assembly: wrapper returns 34,12,78,56,34,12 -> resp_mag=0x1234, resp_phase=0x12345678, resp_valid 1 cycle after the 6th byte.
- TX backpressure: X=-15000 (0xC568), Y=10000 (0x2710); link_tx_ready low 3 cycles on byte 2 -> link_tx_data held at C5 with valid high; order 68,C5,10,27 preserved.
- RX gaps plus response stall: link_rx_valid toggled 1/0 and resp_ready low 5 cycles -> correct reassembly; resp held stable; req_ready=0 and a new req_valid is ignored until the handshake.
- Reset mid-RECV after 3 rx bytes -> next cycle IDLE, req_ready=1, resp_valid=0. A following X=25000, Y=-12000 request produces bytes A8,61,20,D1.
- With CORDIC_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16: no rx bytes arrive -> resp_valid=1, resp_err=1 at cycle 16 of RECV, mag/phase 0.

Source files
------------

// File: rtl/cordic_byte_host_if.sv
// Bundle of the parallel request/response signals and the 8-bit byte link
// between the host block and the byte-serial CORDIC wrapper.
//   slave  : view taken by cordic_byte_host itself
//   master : view taken by whatever drives the host (SoC logic + wrapper model)
interface cordic_byte_host_if #(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 32
);
  // Parallel request side
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_x;
  logic [WIDTH-1:0]   req_y;

  // Parallel response side
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_mag;
  logic [PHASE_W-1:0] resp_phase;
  logic               resp_err;
  logic               busy;

  // Byte link towards the wrapper (ui_in / uo_out / uio handshake)
  logic [7:0]         link_tx_data;
  logic               link_tx_valid;
  logic               link_tx_ready;
  logic [7:0]         link_rx_data;
  logic               link_rx_valid;
  logic               link_rx_ready;

  modport slave (
    input  req_valid, req_x, req_y, resp_ready,
    input  link_tx_ready, link_rx_data, link_rx_valid,
    output req_ready, resp_valid, resp_mag, resp_phase, resp_err, busy,
    output link_tx_data, link_tx_valid, link_rx_ready
  );

  modport master (
    output req_valid, req_x, req_y, resp_ready,
    output link_tx_ready, link_rx_data, link_rx_valid,
    input  req_ready, resp_valid, resp_mag, resp_phase, resp_err, busy,
    input  link_tx_data, link_tx_valid, link_rx_ready
  );
endinterface

// File: rtl/cordic_byte_host.sv
// cordic_byte_host: host-side link master for the byte-serial CORDIC wrapper.
// Takes one parallel (X, Y) request, sends it LSB-first as 2*WIDTH/8 bytes
// (X before Y), collects (WIDTH+PHASE_W)/8 result bytes (magnitude, then
// phase, each LSB-first) and presents them as one parallel response.
// Optional watchdog: define CORDIC_HOST_TIMEOUT_EN to abort a stalled link
// transfer after TIMEOUT_CYCLES cycles with resp_err set.
module cordic_byte_host #(
  parameter int WIDTH          = 16,
  parameter int PHASE_W        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst,
  cordic_byte_host_if.slave  bus
);

  localparam int TX_W      = 2 * WIDTH;
  localparam int RX_W      = WIDTH + PHASE_W;
  localparam int TX_BYTES  = TX_W / 8;
  localparam int RX_BYTES  = RX_W / 8;
  localparam int MAX_BYTES = (TX_BYTES > RX_BYTES) ? TX_BYTES : RX_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(TX_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RX_BYTES - 1);

  // Elaboration-time parameter sanity checks
  if ((WIDTH < 8) || (WIDTH % 8 != 0)) begin : g_bad_width
    $error("cordic_byte_host: WIDTH must be a positive multiple of 8");
  end
  if ((PHASE_W < 8) || (PHASE_W % 8 != 0)) begin : g_bad_phase_w
    $error("cordic_byte_host: PHASE_W must be a positive multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cordic_byte_host: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RECV,
    S_DONE
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [TX_W-1:0]    tx_sr_q,  tx_sr_d;
  // The byte arriving this cycle is the MSB byte of the full RX register, so
  // only the RX_W-8 bits of bytes already received need to be stored.
  logic [RX_W-9:0]    rx_sr_q,  rx_sr_d;
  logic [WIDTH-1:0]   mag_q,    mag_d;
  logic [PHASE_W-1:0] phase_q,  phase_d;

  logic               tx_fire;
  logic               rx_fire;
  logic               resp_fire;
  logic               timeout_hit;
  logic [RX_W-1:0]    rx_full;

  assign tx_fire   = (state_q == S_SEND) && bus.link_tx_ready;
  assign rx_fire   = (state_q == S_RECV) && bus.link_rx_valid;
  assign resp_fire = (state_q == S_DONE) && bus.resp_ready;

  // Full RX register view with the incoming byte shifted in at the MSB end
  assign rx_full = {bus.link_rx_data, rx_sr_q};

  // Next-state, byte counter, shift registers and response holding registers
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    mag_d   = mag_q;
    phase_d = phase_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          tx_sr_d = {bus.req_y, bus.req_x};
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_fire) begin
          tx_sr_d = tx_sr_q >> 8;
          if (cnt_q == LAST_TX) begin
            cnt_d   = '0;
            state_d = S_RECV;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          cnt_d   = '0;
          mag_d   = '0;
          phase_d = '0;
          state_d = S_DONE;
        end
      end

      S_RECV: begin
        if (rx_fire) begin
          rx_sr_d = rx_full[RX_W-1:8];
          if (cnt_q == LAST_RX) begin
            cnt_d   = '0;
            mag_d   = rx_full[WIDTH-1:0];
            phase_d = rx_full[RX_W-1:WIDTH];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          cnt_d   = '0;
          mag_d   = '0;
          phase_d = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (resp_fire) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

`ifdef CORDIC_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            resp_err_q, resp_err_d;

  // Fires in the last allowed cycle without a byte; the transfer aborts at
  // the following edge.
  assign timeout_hit = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts idle link cycles; clears on state entry and on any byte
  always_comb begin
    wdog_d = '0;
    if (((state_q == S_SEND) || (state_q == S_RECV)) &&
        (state_d == state_q) && !tx_fire && !rx_fire) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Error flag: set on a watchdog abort, cleared by the response handshake
  always_comb begin
    resp_err_d = resp_err_q;
    if (resp_fire) begin
      resp_err_d = 1'b0;
    end else if (((state_q == S_SEND) || (state_q == S_RECV)) &&
                 timeout_hit && !tx_fire && !rx_fire) begin
      resp_err_d = 1'b1;
    end
  end

  // Watchdog and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  // Without the watchdog the block waits on the link indefinitely.
  assign timeout_hit  = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // Outputs are decoded from registered state, so they are glitch-free and
  // drop to their idle values the cycle after a reset.
  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.link_tx_valid = (state_q == S_SEND);
  assign bus.link_tx_data  = tx_sr_q[7:0];
  assign bus.link_rx_ready = (state_q == S_RECV);
  assign bus.resp_valid    = (state_q == S_DONE);
  assign bus.resp_mag      = mag_q;
  assign bus.resp_phase    = phase_q;

endmodule

// File: tb/tb_cordic_byte_host.sv
// Directed self-checking bench for cordic_byte_host (WIDTH=16, PHASE_W=32).
// The watchdog scenario is compiled in when CORDIC_HOST_TIMEOUT_EN is defined.
module tb_cordic_byte_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cordic_byte_host_if #(.WIDTH(16), .PHASE_W(32)) bus ();

  cordic_byte_host #(
    .WIDTH          (16),
    .PHASE_W        (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not reach the summary");
    $fatal(1, "time limit expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle (caller ensures the block is idle)
  task automatic start_req(input logic [15:0] x, input logic [15:0] y);
    check("req_ready before request", 64'(bus.req_ready), 64'd1);
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Expect a given tx byte presented this cycle, then advance one cycle
  task automatic expect_tx(input string tag, input logic [7:0] b);
    check({tag, " tx_valid"}, 64'(bus.link_tx_valid), 64'd1);
    check({tag, " tx_data"}, 64'(bus.link_tx_data), 64'(b));
    step();
  endtask

  // Offer one rx byte for one cycle
  task automatic push_rx(input logic [7:0] b);
    check("rx_ready on push", 64'(bus.link_rx_ready), 64'd1);
    bus.link_rx_valid = 1'b1;
    bus.link_rx_data  = b;
    step();
    bus.link_rx_valid = 1'b0;
  endtask

  task automatic handshake_resp();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("resp_valid after handshake", 64'(bus.resp_valid), 64'd0);
    check("req_ready after handshake", 64'(bus.req_ready), 64'd1);
    check("busy after handshake", 64'(bus.busy), 64'd0);
    check("resp_err after handshake", 64'(bus.resp_err), 64'd0);
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_x         = '0;
    bus.req_y         = '0;
    bus.resp_ready    = 1'b0;
    bus.link_tx_ready = 1'b1;
    bus.link_rx_data  = '0;
    bus.link_rx_valid = 1'b0;

    // ---- Reset state ----
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst req_ready", 64'(bus.req_ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst resp_mag", 64'(bus.resp_mag), 64'd0);
    check("rst resp_phase", 64'(bus.resp_phase), 64'd0);
    check("rst resp_err", 64'(bus.resp_err), 64'd0);
    check("rst tx_valid", 64'(bus.link_tx_valid), 64'd0);
    check("rst tx_data", 64'(bus.link_tx_data), 64'd0);
    check("rst rx_ready", 64'(bus.link_rx_ready), 64'd0);

    // ---- Q1: X=12000, Y=8000, link always ready ----
    start_req(16'h2EE0, 16'h1F40);
    check("q1 req_ready in SEND", 64'(bus.req_ready), 64'd0);
    check("q1 busy in SEND", 64'(bus.busy), 64'd1);
    expect_tx("q1 b0", 8'hE0);
    expect_tx("q1 b1", 8'h2E);
    expect_tx("q1 b2", 8'h40);
    expect_tx("q1 b3", 8'h1F);
    check("q1 tx_valid in RECV", 64'(bus.link_tx_valid), 64'd0);
    check("q1 rx_ready in RECV", 64'(bus.link_rx_ready), 64'd1);
    push_rx(8'h34);
    push_rx(8'h12);
    push_rx(8'h78);
    push_rx(8'h56);
    push_rx(8'h34);
    check("q1 resp_valid before last byte", 64'(bus.resp_valid), 64'd0);
    push_rx(8'h12);
    check("q1 resp_valid", 64'(bus.resp_valid), 64'd1);
    check("q1 resp_mag", 64'(bus.resp_mag), 64'h1234);
    check("q1 resp_phase", 64'(bus.resp_phase), 64'h1234_5678);
    check("q1 resp_err", 64'(bus.resp_err), 64'd0);
    check("q1 rx_ready in DONE", 64'(bus.link_rx_ready), 64'd0);
    handshake_resp();

    // ---- Q2: X=-15000, Y=10000 with tx backpressure on byte 2 ----
    start_req(16'hC568, 16'h2710);
    expect_tx("q2 b0", 8'h68);
    bus.link_tx_ready = 1'b0;
    expect_tx("q2 hold1", 8'hC5);
    expect_tx("q2 hold2", 8'hC5);
    expect_tx("q2 hold3", 8'hC5);
    bus.link_tx_ready = 1'b1;
    expect_tx("q2 b1", 8'hC5);
    expect_tx("q2 b2", 8'h10);
    expect_tx("q2 b3", 8'h27);
    check("q2 in RECV", 64'(bus.link_rx_ready), 64'd1);
    // RX with one idle cycle between bytes: mag=BEEF, phase=DEADC0DE
    push_rx(8'hEF); step();
    push_rx(8'hBE); step();
    push_rx(8'hDE); step();
    push_rx(8'hC0); step();
    push_rx(8'hAD); step();
    check("q2 no resp during gaps", 64'(bus.resp_valid), 64'd0);
    push_rx(8'hDE);
    // Response stall with a competing request that must be ignored
    bus.req_valid = 1'b1;
    bus.req_x     = 16'h7777;
    bus.req_y     = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      check("q2 stall resp_valid", 64'(bus.resp_valid), 64'd1);
      check("q2 stall resp_mag", 64'(bus.resp_mag), 64'hBEEF);
      check("q2 stall resp_phase", 64'(bus.resp_phase), 64'hDEAD_C0DE);
      check("q2 stall req_ready", 64'(bus.req_ready), 64'd0);
      check("q2 stall tx_valid", 64'(bus.link_tx_valid), 64'd0);
      step();
    end
    bus.req_valid = 1'b0;
    handshake_resp();
    check("q2 request not queued", 64'(bus.link_tx_valid), 64'd0);
    step();
    check("q2 still idle", 64'(bus.busy), 64'd0);

    // ---- Q3: reset in the middle of RECV ----
    start_req(16'h0001, 16'h0002);
    expect_tx("q3 b0", 8'h01);
    expect_tx("q3 b1", 8'h00);
    expect_tx("q3 b2", 8'h02);
    expect_tx("q3 b3", 8'h00);
    push_rx(8'hAA);
    push_rx(8'hBB);
    push_rx(8'hCC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst req_ready", 64'(bus.req_ready), 64'd1);
    check("midrst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst rx_ready", 64'(bus.link_rx_ready), 64'd0);
    check("midrst tx_valid", 64'(bus.link_tx_valid), 64'd0);
    check("midrst tx_data", 64'(bus.link_tx_data), 64'd0);
    step();
    step();
    check("midrst no residual resp", 64'(bus.resp_valid), 64'd0);

    // X=25000, Y=-12000 after the reset
    start_req(16'h61A8, 16'hD120);
    expect_tx("q4 b0", 8'hA8);
    expect_tx("q4 b1", 8'h61);
    expect_tx("q4 b2", 8'h20);
    expect_tx("q4 b3", 8'hD1);
    push_rx(8'h02);
    push_rx(8'h01);
    push_rx(8'h0D);
    push_rx(8'h0C);
    push_rx(8'h0B);
    push_rx(8'h0A);
    check("q4 resp_valid", 64'(bus.resp_valid), 64'd1);
    check("q4 resp_mag", 64'(bus.resp_mag), 64'h0102);
    check("q4 resp_phase", 64'(bus.resp_phase), 64'h0A0B_0C0D);
    handshake_resp();

`ifdef CORDIC_HOST_TIMEOUT_EN
    // ---- Watchdog: no rx bytes ever arrive ----
    begin
      int n_wait;
      start_req(16'h0005, 16'h0006);
      expect_tx("wd b0", 8'h05);
      expect_tx("wd b1", 8'h00);
      expect_tx("wd b2", 8'h06);
      expect_tx("wd b3", 8'h00);
      n_wait = 0;
      while (!bus.resp_valid && n_wait < 40) begin
        step();
        n_wait++;
      end
      check("wd cycles in RECV", 64'(n_wait), 64'd16);
      check("wd resp_valid", 64'(bus.resp_valid), 64'd1);
      check("wd resp_err", 64'(bus.resp_err), 64'd1);
      check("wd resp_mag", 64'(bus.resp_mag), 64'd0);
      check("wd resp_phase", 64'(bus.resp_phase), 64'd0);
      check("wd rx_ready", 64'(bus.link_rx_ready), 64'd0);
      handshake_resp();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
